add_sub_bist: RTL
=================

// Module: add_sub_bist
// PURPOSE
//   Built-in self-test driver/checker for the WIDTH-bit add/sub unit: the other end of its interface.
//   - Drives a, b, mode into the unit; samples sum and carry back.
//   - Sweeps every {mode,a,b} combination and compares each result against a golden model.
//   - Counts mismatches and reports pass/fail.
//   - Sits beside the add/sub unit in the datapath test wrapper.
// PARAMETERS
//   WIDTH          4   operand/sum width (same as the add/sub unit)
//   SETTLE_CYCLES  1   cycles the vector is held before the check cycle; legal values >=1
//   ERR_W          16  err_count width
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous reset, active-low
//   start      in   1        1-cycle request to begin a sweep
//   a          out  WIDTH    operand A to the unit (registered)
//   b          out  WIDTH    operand B to the unit (registered)
//   mode       out  1        0 = add, 1 = subtract (registered)
//   sum        in   WIDTH    result from the unit
//   carry      in   1        carry-out from the unit
//   busy       out  1        sweep in progress
//   done       out  1        sweep finished; held until the next accepted start
//   pass       out  1        done && err_count==0
//   err_count  out  ERR_W    mismatch count; saturates at all-ones
// BEHAVIOUR
//   - Reset (rst_n=0, any time, including mid-sweep):
//     - a, b, mode, busy, done, pass, err_count and the index are all 0.
//     - State returns to IDLE.
//   - Vector index idx is 2*WIDTH+1 bits, with {mode,a,b}=idx (b is the LSBs).
//     - Sweep covers idx 0 .. 2^(2W+1)-1, which is 512 vectors at the defaults.
//   - Golden model, computed in W+1 bits:
//     - {carry,sum} = a + (b ^ {W{mode}}) + mode.
//     - For subtract, carry=1 means no borrow.
//   - States and transitions:
//     - IDLE: on start=1 -> load idx=0 onto a/b/mode, busy=1, clear err_count, go to SETTLE.
//     - SETTLE: hold the vector for SETTLE_CYCLES cycles, then go to CHECK.
//     - CHECK: one cycle. On the exiting edge, compare sum/carry with the golden model; mismatch -> err_count+1 (saturating).
//       - If idx is not the last vector: idx+1, drive the new vector, go to SETTLE.
//       - Else: go to DONE.
//     - DONE: busy=0, done=1, pass valid. start=1 -> same as the start action in IDLE (done drops).
//   - Timing:
//     - Each vector takes SETTLE_CYCLES+1 cycles.
//     - done rises 2^(2W+1)*(SETTLE_CYCLES+1) edges after the start-accept edge: 1024 at the defaults.
//   - start while busy is ignored.
//   - a/b/mode change only on a start-accept edge or a CHECK-exit edge, so the unit sees stable inputs for a whole vector.
//   - pass is 0 whenever done=0.
// CONFIGURATION
//   BIST_STOP_ON_FAIL_EN
//     - Defined: the first mismatch in CHECK ends the sweep immediately.
//       - err_count=1, done=1, pass=0.
//       - a/b/mode stay frozen at the failing vector until the next start or reset.
//     - Undefined: the sweep always runs to the last vector and counts every mismatch.
// TESTING
//   1. Correct add/sub unit, start pulse -> done at edge 1024; pass=1; err_count=0; busy high for exactly 1024 cycles.
//   2. Spot-check vectors in CHECK:
//      - a=0101 b=0011 m=1 -> model sum=0010 c=1.
//      - a=1000 b=0010 m=0 -> sum=1010 c=0.
//      - a=0011 b=0101 m=1 -> sum=1110 c=0.
//   3. Faults injected into the unit (feature undefined):
//      - sum[0] stuck-at-0 -> err_count=256, pass=0.
//      - carry inverted -> err_count=512.
//   4. BIST_STOP_ON_FAIL_EN defined, sum[0] stuck-at-0 -> stops at idx 1 (a=0000 b=0001 m=0); err_count=1; done=1.
//   5. rst_n low at cycle 300 of a sweep -> all outputs 0 at once (async); new start -> full clean sweep, pass=1.
//   6. start re-pulsed at cycle 50 while busy -> ignored; done still at edge 1024.
//      - start in DONE -> done drops next edge; a new sweep runs.

Source files
------------

// File: rtl/add_sub_bist.sv
// Built-in self-test driver/checker for a WIDTH-bit add/sub unit.
// Latency: SETTLE_CYCLES+1 cycles per vector, 2^(2*WIDTH+1) vectors per sweep.
// Backpressure: none; start is ignored while busy, a new start in DONE restarts.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             1-cycle sweep request (accepted in IDLE or DONE)
//   a, b, mode        registered stimulus to the unit ({mode,a,b} = vector index)
//   sum, carry        result returned by the unit
//   busy, done, pass  sweep status; pass = done && err_count==0
//   err_count         saturating mismatch count
// Optional feature macro: BIST_STOP_ON_FAIL_EN (end the sweep at the first mismatch).
module add_sub_bist #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             mode,
    input  logic [WIDTH-1:0] sum,
    input  logic             carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
);

    localparam int IDX_W = 2 * WIDTH + 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err;

    logic [WIDTH:0]   w_gold;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_nxt;
    logic             w_last;

    // The stimulus outputs are the index register itself, so they only move
    // when the index does (start accept or CHECK exit).
    assign b         = r_idx[WIDTH-1:0];
    assign a         = r_idx[2*WIDTH-1:WIDTH];
    assign mode      = r_idx[IDX_W-1];
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;

    // Subtract is a + ~b + 1, so carry=1 means "no borrow".
    assign w_gold     = {1'b0, a} + {1'b0, b ^ {WIDTH{mode}}} + {{WIDTH{1'b0}}, mode};
    assign w_mismatch = (w_gold != {carry, sum});
    assign w_last     = &r_idx;

    always_comb begin
        w_err_nxt = r_err;
        if (w_mismatch && !(&r_err)) begin
            w_err_nxt = r_err + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_SETTLE;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_err   <= '0;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_CHECK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    r_err <= w_err_nxt;
`ifdef BIST_STOP_ON_FAIL_EN
                    // Freeze on the failing vector so it can be inspected.
                    if (w_mismatch || w_last) begin
`else
                    if (w_last) begin
`endif
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_nxt == '0);
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= S_SETTLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
